get_height: RTL and testbench

- Pitch-to-height estimator for the pitch game.
- Collects 12-bit unsigned microphone samples into a 64-entry signed window.
- Counts hysteresis zero-crossings per 64-sample frame and converts the count to a raw height.
- Smooths the raw height over the last 16 frames; the result drives the player sprite's vertical position.

---
 rtl/get_height.sv | 153 +++++++++++++++
 tb/tb_get_height.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/get_height.sv
// get_height: zero-crossing pitch estimator producing a 16-frame smoothed sprite height.
// Optional GET_HEIGHT_SILENCE_EN gates frames whose peak |sample| is below SILENCE_LEVEL to height 0.
module get_height #(
    parameter int FRAME_LEN    = 64,
    parameter int HYST         = 64,
    parameter int HEIGHT_SCALE = 10
`ifdef GET_HEIGHT_SILENCE_EN
    ,
    parameter int SILENCE_LEVEL = 128
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mic_valid,
    input  logic [11:0]                 mic_data,
    output logic [FRAME_LEN-1:0][15:0]  mic_data_shift,
    output logic [15:0][9:0]            height_history,
    output logic [13:0]                 sum_of_heights,
    output logic [9:0]                  height,
    output logic                        height_valid
);

    localparam int SCW = $clog2(FRAME_LEN);
    localparam logic [SCW-1:0]     LAST_SAMPLE = SCW'(FRAME_LEN - 1);
    localparam logic signed [15:0] HYST_POS    = 16'(HYST);
    localparam logic signed [15:0] HYST_NEG    = 16'(-HYST);

    typedef enum logic {
        NEG = 1'b0,
        POS = 1'b1
    } schmitt_e;

    logic [11:0]        w_sampleOffset;
    logic signed [15:0] w_sample;
    schmitt_e           r_schmitt;
    schmitt_e           w_schmittNext;
    logic               w_crossing;
    logic [6:0]         r_crossCount;
    logic [6:0]         w_crossCountNext;
    logic [6:0]         r_frameCross;
    logic [SCW-1:0]     r_sampleCount;
    logic               w_frameEnd;
    logic               r_frameDone;
    logic [31:0]        w_product;
    logic [9:0]         w_raw;
    logic [13:0]        w_sumNext;

    // Subtracting midscale is just an MSB flip; then sign-extend to 16 bits.
    assign w_sampleOffset = {~mic_data[11], mic_data[10:0]};
    assign w_sample       = {{4{w_sampleOffset[11]}}, w_sampleOffset};
    assign w_frameEnd     = (r_sampleCount == LAST_SAMPLE);

    always_comb begin
        w_schmittNext = r_schmitt;
        w_crossing    = 1'b0;
        if (r_schmitt == NEG) begin
            if (w_sample >= HYST_POS) begin
                w_schmittNext = POS;
                w_crossing    = 1'b1;
            end
        end else begin
            if (w_sample <= HYST_NEG) begin
                w_schmittNext = NEG;
                w_crossing    = 1'b1;
            end
        end
        w_crossCountNext = r_crossCount;
        if (w_crossing && (r_crossCount != 7'd127)) begin
            w_crossCountNext = r_crossCount + 7'd1;
        end
    end

    // The latched frame count includes the frame's last sample; Schmitt state carries across frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mic_data_shift <= '0;
            r_schmitt      <= NEG;
            r_crossCount   <= '0;
            r_frameCross   <= '0;
            r_sampleCount  <= '0;
            r_frameDone    <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (mic_valid) begin
                mic_data_shift <= {mic_data_shift[FRAME_LEN-2:0], w_sample};
                r_schmitt      <= w_schmittNext;
                if (w_frameEnd) begin
                    r_sampleCount <= '0;
                    r_frameCross  <= w_crossCountNext;
                    r_crossCount  <= '0;
                    r_frameDone   <= 1'b1;
                end else begin
                    r_sampleCount <= r_sampleCount + SCW'(1);
                    r_crossCount  <= w_crossCountNext;
                end
            end
        end
    end

`ifdef GET_HEIGHT_SILENCE_EN
    logic [11:0] w_magnitude;
    logic [11:0] w_peakNext;
    logic [11:0] r_peak;
    logic [11:0] r_framePeak;

    assign w_magnitude = w_sample[15] ? 12'(-w_sample) : w_sample[11:0];
    assign w_peakNext  = (w_magnitude > r_peak) ? w_magnitude : r_peak;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak      <= '0;
            r_framePeak <= '0;
        end else if (mic_valid) begin
            if (w_frameEnd) begin
                r_framePeak <= w_peakNext;
                r_peak      <= '0;
            end else begin
                r_peak <= w_peakNext;
            end
        end
    end
`endif

    always_comb begin
        w_product = 32'(r_frameCross) * 32'(HEIGHT_SCALE);
        w_raw     = (w_product > 32'd1023) ? 10'd1023 : w_product[9:0];
`ifdef GET_HEIGHT_SILENCE_EN
        if (r_framePeak < 12'(SILENCE_LEVEL)) begin
            w_raw = 10'd0;
        end
`endif
        // Running sum: add the newest raw height and drop the one falling off the history.
        w_sumNext = sum_of_heights + {4'd0, w_raw} - {4'd0, height_history[15]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            height_history <= '0;
            sum_of_heights <= '0;
            height         <= '0;
            height_valid   <= 1'b0;
        end else begin
            height_valid <= 1'b0;
            if (r_frameDone) begin
                height_history <= {height_history[14:0], w_raw};
                sum_of_heights <= w_sumNext;
                height         <= w_sumNext[13:4];
                height_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_get_height.sv
// tb_get_height: randomized self-checking bench for get_height against a queue-based frame model.
// The DUT runs with HEIGHT_SCALE=16 so the 1023 clamp is reachable within a 64-sample frame.
module tb_get_height;

    localparam int SCALE = 16;

    logic              clk;
    logic              reset;
    logic              mic_valid;
    logic [11:0]       mic_data;
    logic [63:0][15:0] mic_data_shift;
    logic [15:0][9:0]  height_history;
    logic [13:0]       sum_of_heights;
    logic [9:0]        height;
    logic              height_valid;

    int checks;
    int errors;
    int pulses;
    int win[$];
    int frameQ[$];
    int hist[$];
    int modelState;
    bit pending;
    int pendRaw;
    bit expValid;

    get_height #(.HEIGHT_SCALE(SCALE)) dut (
        .clk            (clk),
        .reset          (reset),
        .mic_valid      (mic_valid),
        .mic_data       (mic_data),
        .mic_data_shift (mic_data_shift),
        .height_history (height_history),
        .sum_of_heights (sum_of_heights),
        .height         (height),
        .height_valid   (height_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        win.delete();
        hist.delete();
        frameQ.delete();
        repeat (64) win.push_back(0);
        repeat (16) hist.push_back(0);
        modelState = 0;
        pending    = 1'b0;
        pendRaw    = 0;
    endfunction

    // Crossings for a whole frame, walking its samples with the carried-over Schmitt state.
    function automatic int frameRaw();
        int c;
        int peak;
        int raw;
        c    = 0;
        peak = 0;
        foreach (frameQ[i]) begin
            int s;
            s = frameQ[i];
            if ((s < 0 ? -s : s) > peak) peak = (s < 0 ? -s : s);
            if (modelState == 0 && s >= 64) begin
                modelState = 1;
                c++;
            end else if (modelState == 1 && s <= -64) begin
                modelState = 0;
                c++;
            end
        end
        if (c > 127) c = 127;
        raw = c * SCALE;
        if (raw > 1023) raw = 1023;
`ifdef GET_HEIGHT_SILENCE_EN
        if (peak < 128) raw = 0;
`endif
        return raw;
    endfunction

    function automatic int histSum();
        int s;
        s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    function automatic void modelEdge(input bit v, input int s);
        expValid = pending;
        if (pending) begin
            hist.push_front(pendRaw);
            void'(hist.pop_back());
            pending = 1'b0;
        end
        if (v) begin
            win.push_front(s);
            void'(win.pop_back());
            frameQ.push_back(s);
            if (frameQ.size() == 64) begin
                pendRaw = frameRaw();
                frameQ.delete();
                pending = 1'b1;
            end
        end
    endfunction

    // Called at a falling edge; drives one cycle, advances the model and checks the outputs.
    task automatic applyStimulus(input bit v, input logic [11:0] d);
        mic_valid = v;
        mic_data  = d;
        @(posedge clk);
        #1;
        modelEdge(v, int'(d) - 2048);
        mic_valid = 1'b0;
        if (height_valid) pulses++;
        checkOutput("height_valid", height_valid, expValid);
        checkOutput("win0", $signed(mic_data_shift[0]), win[0]);
        checkOutput("sum", sum_of_heights, histSum());
        checkOutput("height", height, histSum() / 16);
        checkOutput("hist0", height_history[0], hist[0]);
        checkOutput("hist15", height_history[15], hist[15]);
        @(negedge clk);
    endtask

    task automatic compareWindow();
        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("win%0d", i), $signed(mic_data_shift[i]), win[i]);
        end
    endtask

    task automatic midReset();
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_valid", height_valid, 0);
        checkOutput("rst_sum", sum_of_heights, 0);
        checkOutput("rst_height", height, 0);
        checkOutput("rst_hist0", height_history[0], 0);
        checkOutput("rst_win0", mic_data_shift[0], 0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic squareWave(input int amp, input int half, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 12'($urandom_range(0, 4095)));
            end
            applyStimulus(1'b1, ((i / half) % 2 == 0) ? 12'(2048 + amp) : 12'(2048 - amp));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulses    = 0;
        reset     = 1'b0;
        mic_valid = 1'b0;
        mic_data  = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("init_valid", height_valid, 0);
        checkOutput("init_sum", sum_of_heights, 0);
        checkOutput("init_height", height, 0);
        checkOutput("init_hist", height_history[7], 0);
        reset = 1'b1;

        applyStimulus(1'b1, 12'h800);
        applyStimulus(1'b1, 12'hFFF);
        applyStimulus(1'b1, 12'h000);
        checkOutput("conv0", $signed(mic_data_shift[0]), -2048);
        checkOutput("conv1", $signed(mic_data_shift[1]), 2047);
        checkOutput("conv2", $signed(mic_data_shift[2]), 0);
        compareWindow();

        midReset();
        pulses = 0;
        for (int i = 0; i < 250; i++) applyStimulus(1'b1, 12'(i));
        applyStimulus(1'b0, 12'h0);
        checkOutput("ramp_pulses", pulses, 3);

        midReset();
        squareWave(1000, 4, 64, 1'b0);
        applyStimulus(1'b0, 12'h0);
        checkOutput("sq_hist0", height_history[0], 16 * SCALE);
        checkOutput("sq_sum", sum_of_heights, 16 * SCALE);
        checkOutput("sq_height", height, SCALE);
        squareWave(1000, 4, 15 * 64, 1'b1);
        applyStimulus(1'b0, 12'h0);
        checkOutput("sq16_sum", sum_of_heights, 256 * SCALE);
        checkOutput("sq16_height", height, 16 * SCALE);

        midReset();
        squareWave(50, 4, 128, 1'b1);
        applyStimulus(1'b0, 12'h0);
        checkOutput("hyst_hist0", height_history[0], 0);
        checkOutput("hyst_height", height, 0);

        midReset();
        squareWave(100, 4, 64, 1'b1);
        applyStimulus(1'b0, 12'h0);
`ifdef GET_HEIGHT_SILENCE_EN
        checkOutput("quiet_hist0", height_history[0], 0);
`else
        checkOutput("quiet_hist0", height_history[0], 16 * SCALE);
`endif

        midReset();
        squareWave(1000, 1, 64, 1'b1);
        applyStimulus(1'b0, 12'h0);
        checkOutput("clamp_hist0", height_history[0], 1023);
        checkOutput("clamp_sum1", sum_of_heights, 1023);
        squareWave(1000, 1, 64, 1'b1);
        applyStimulus(1'b0, 12'h0);
        checkOutput("clamp_sum2", sum_of_heights, 2046);

        midReset();
        for (int i = 0; i < 1200; i++) begin
            applyStimulus(1'(($urandom_range(0, 3) != 0)), 12'($urandom_range(0, 4095)));
        end
        midReset();
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 12'($urandom_range(0, 4095)));
        compareWindow();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
